kernel_scan_gen: RTL and testbench
==================================

KERNEL_SCAN_GEN -- requirements
Module: kernel_scan_gen

Interface
REQ-001 The block SHALL have parameter WIDTH_LAST, default 7, meaning the last column index scanned (0..7).
REQ-002 The block SHALL have parameter DEPTH_LAST, default 7, meaning the last row index scanned (0..7).
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-005 Port start SHALL be an input, 1 bit wide: a one-cycle request to begin a frame scan.
REQ-006 Port abort SHALL be an input, 1 bit wide: terminates a scan in progress.
REQ-007 Port addr_ready SHALL be an input, 1 bit wide: downstream accepts the current address.
REQ-008 Port address_width SHALL be an output, [0:2]: the column address fed to the kernel operator stage.
REQ-009 Port address_depth SHALL be an output, [0:2]: the row address fed to the kernel operator stage.
REQ-010 Port addr_valid SHALL be an output, 1 bit wide: address_width and address_depth are valid this cycle.
REQ-011 Port kernel_valid SHALL be an output, 1 bit wide: addr_valid AND addr_ready delayed one cycle, aligned to the registered outputs of the operator stage.
REQ-012 Port busy SHALL be an output, 1 bit wide: high in SCAN and LAST.
REQ-013 Port done SHALL be an output, 1 bit wide: a one-cycle pulse at the end of the frame.
REQ-014 Port frame_cnt SHALL be an output, 8 bits wide: the number of completed frames, wrapping at 255 -> 0.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN, LAST and DONE.
REQ-016 IDLE -> SCAN SHALL occur on start; the first address presented SHALL be (width=W_FIRST, depth=0).
REQ-017 In SCAN, addr_valid SHALL be 1, and an address SHALL advance only on a cycle where addr_ready=1 (transfer).
REQ-018 Advance order SHALL be width-major: width increments to WIDTH_LAST, then wraps to W_FIRST and depth increments.
REQ-019 On the transfer of (WIDTH_LAST_EFF, DEPTH_LAST), the FSM SHALL go SCAN -> LAST; LAST SHALL last one cycle with addr_valid=0 while the final kernel_valid drains, then go LAST -> DONE.
REQ-020 DONE SHALL assert done for one cycle, increment frame_cnt, and return to IDLE.
REQ-021 While addr_ready=0, the address and addr_valid SHALL hold stable (no change until transfer).
REQ-022 start SHALL be ignored outside IDLE; start in the DONE cycle SHALL NOT be queued.
REQ-023 abort in SCAN or LAST SHALL, on the next edge, go to IDLE, clear addr_valid, zero the addresses, not pulse done, and not increment frame_cnt; abort and a final transfer in the same cycle SHALL resolve as abort.
REQ-024 A frame without stalls SHALL produce exactly (WIDTH_LAST_EFF-W_FIRST+1)*(DEPTH_LAST+1) kernel_valid pulses, with done exactly 2 cycles after the final transfer.
REQ-025 In IDLE, address_width and address_depth SHALL be 0 and addr_valid SHALL be 0.

Reset
REQ-026 With rst_n=0, the state SHALL be IDLE, all outputs 0, and frame_cnt 0, immediately and independent of clk.
REQ-027 Reset asserted mid-scan SHALL discard the frame; after release, the block SHALL wait for a new start.

Configuration
REQ-028 With KERNEL_SCAN_BORDER_SKIP_EN defined, W_FIRST SHALL be 1 and WIDTH_LAST_EFF SHALL be min(WIDTH_LAST,6), so the operator's width+1/width-1 never wraps.
REQ-029 Without KERNEL_SCAN_BORDER_SKIP_EN, W_FIRST SHALL be 0 and WIDTH_LAST_EFF SHALL be WIDTH_LAST.

Structure
REQ-030 The state encoding (IDLE=0, SCAN=1, LAST=2, DONE=3) and the 3-bit address width constant SHALL reside in shared package kernel_pkg.
REQ-031 The column/row counter pair with wrap SHALL be one sub-module, kernel_addr_counter (inputs: clr, adv; outputs: width, depth, last).
REQ-032 No other sub-modules SHALL be created.

Verification
REQ-033 Reset, then start with addr_ready=1 and defaults -> 64 kernel_valid pulses, addresses (0,0)..(7,7) in order, done at the 2nd cycle after (7,7), frame_cnt=1.
REQ-034 addr_ready toggling 1/0 every cycle -> each address held exactly 2 cycles, still 64 transfers, no skipped or repeated address.
REQ-035 abort asserted on the transfer of (3,2) -> next cycle busy=0, addr_valid=0, no done pulse, frame_cnt unchanged.
REQ-036 KERNEL_SCAN_BORDER_SKIP_EN defined -> 48 transfers, widths 1..6 only, first (1,0), last (6,7).
REQ-037 rst_n dropped mid-frame at (5,4), then released and start issued -> outputs 0 asynchronously, new scan begins at (0,0), frame_cnt=0.
REQ-038 256 back-to-back frames with start issued in IDLE -> frame_cnt wraps to 0; start issued during the DONE cycle is ignored.

Source files
------------

// File: rtl/kernel_pkg.sv
// Shared state encoding, address width and helpers for the kernel scan generator.
package kernel_pkg;

   localparam int unsigned AddrW = 3;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StScan = 2'd1,
      StLast = 2'd2,
      StDone = 2'd3
   } kernel_state_e;

   // With the border skipped, column 7 is never centred so width+1 stays in range.
   function automatic int unsigned eff_width_last(input int unsigned width_last);
      return (width_last < 6) ? width_last : 6;
   endfunction

endpackage

// File: rtl/kernel_addr_counter.sv
// Width-major column/row counter with wrap; clr reloads (WFirst, 0), adv steps one address.
module kernel_addr_counter
   import kernel_pkg::*;
#(
   parameter int unsigned WFirst = 0,
   parameter int unsigned WLast  = 7,
   parameter int unsigned DLast  = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   output logic [AddrW-1:0] width,
   output logic [AddrW-1:0] depth,
   output logic             last
);

   localparam logic [AddrW-1:0] WFirstL = AddrW'(WFirst);
   localparam logic [AddrW-1:0] WLastL  = AddrW'(WLast);
   localparam logic [AddrW-1:0] DLastL  = AddrW'(DLast);

   logic [AddrW-1:0] r_width;
   logic [AddrW-1:0] r_depth;
   logic [AddrW-1:0] w_width_nxt;
   logic [AddrW-1:0] w_depth_nxt;
   logic             w_width_wrap;

   assign w_width_wrap = (r_width == WLastL);

   always_comb begin
      w_width_nxt = r_width;
      w_depth_nxt = r_depth;
      if (clr) begin
         w_width_nxt = WFirstL;
         w_depth_nxt = '0;
      end else if (adv) begin
         if (w_width_wrap) begin
            w_width_nxt = WFirstL;
            w_depth_nxt = (r_depth == DLastL) ? '0 : r_depth + 1'b1;
         end else begin
            w_width_nxt = r_width + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_width <= WFirstL;
         r_depth <= '0;
      end else begin
         r_width <= w_width_nxt;
         r_depth <= w_depth_nxt;
      end
   end

   assign width = r_width;
   assign depth = r_depth;
   assign last  = w_width_wrap && (r_depth == DLastL);

endmodule

// File: rtl/kernel_scan_gen.sv
// Frame address scanner feeding a kernel operator stage with a valid/ready handshake.
// Define KERNEL_SCAN_BORDER_SKIP_EN to skip the left/right border columns.
module kernel_scan_gen
   import kernel_pkg::*;
#(
   parameter int unsigned WIDTH_LAST = 7,
   parameter int unsigned DEPTH_LAST = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       addr_ready,
   output logic [0:2] address_width,
   output logic [0:2] address_depth,
   output logic       addr_valid,
   output logic       kernel_valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] frame_cnt
);

`ifdef KERNEL_SCAN_BORDER_SKIP_EN
   localparam int unsigned WFirst   = 1;
   localparam int unsigned WLastEff = eff_width_last(WIDTH_LAST);
`else
   localparam int unsigned WFirst   = 0;
   localparam int unsigned WLastEff = WIDTH_LAST;
`endif

   kernel_state_e    r_state;
   kernel_state_e    w_state_nxt;
   logic             r_kernel_valid;
   logic [7:0]       r_frame_cnt;
   logic             w_xfer;
   logic             w_clr;
   logic             w_last;
   logic [AddrW-1:0] w_cnt_width;
   logic [AddrW-1:0] w_cnt_depth;

   assign w_xfer = (r_state == StScan) && addr_ready;
   // Clearing on abort (and whenever not scanning) means a new frame always starts at its origin.
   assign w_clr  = (r_state != StScan) || abort;

   kernel_addr_counter #(
      .WFirst (WFirst),
      .WLast  (WLastEff),
      .DLast  (DEPTH_LAST)
   ) u_addr_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr),
      .adv   (w_xfer),
      .width (w_cnt_width),
      .depth (w_cnt_depth),
      .last  (w_last)
   );

   always_comb begin
      w_state_nxt = r_state;
      addr_valid  = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) w_state_nxt = StScan;
         end
         StScan: begin
            addr_valid = 1'b1;
            busy       = 1'b1;
            if (abort) w_state_nxt = StIdle;
            else if (addr_ready && w_last) w_state_nxt = StLast;
         end
         StLast: begin
            busy        = 1'b1;
            w_state_nxt = abort ? StIdle : StDone;
         end
         StDone: begin
            done        = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= StIdle;
         r_kernel_valid <= 1'b0;
         r_frame_cnt    <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_kernel_valid <= w_xfer;
         if (r_state == StDone) r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   assign address_width = (r_state == StScan) ? w_cnt_width : '0;
   assign address_depth = (r_state == StScan) ? w_cnt_depth : '0;
   assign kernel_valid  = r_kernel_valid;
   assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_kernel_scan_gen.sv
// Self-checking bench for kernel_scan_gen: vector table of frame scenarios plus address scoreboard.
module tb_kernel_scan_gen;

`ifdef KERNEL_SCAN_BORDER_SKIP_EN
   localparam int WFirst   = 1;
   localparam int WLastEff = 6;
`else
   localparam int WFirst   = 0;
   localparam int WLastEff = 7;
`endif
   localparam int NW     = WLastEff - WFirst + 1;
   localparam int ND     = 8;
   localparam int Tot    = NW * ND;
   localparam int Idx32  = 2 * NW + (3 - WFirst);
   localparam int Idx54  = 4 * NW + (5 - WFirst);
   localparam int MaxCyc = 1000;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       addr_ready;
   logic [2:0] address_width;
   logic [2:0] address_depth;
   logic       addr_valid;
   logic       kernel_valid;
   logic       busy;
   logic       done;
   logic [7:0] frame_cnt;

   typedef struct {
      logic [2:0] w;
      logic [2:0] d;
   } addr_t;

   // mode: 0 ready always, 1 ready toggling, 2 ready and start random
   typedef struct {
      int mode;
      int abort_idx;
      int abort_last;
      int start_in_done;
      int exp_xfers;
      int exp_kv;
      int exp_done;
      int exp_fdelta;
   } vec_t;

   addr_t      exp_q[$];
   vec_t       vecs[6];
   vec_t       wrapv;
   int         n_tests;
   int         n_fail;
   int         cyc = 0;
   int         xfer_cnt;
   int         kv_cnt;
   int         done_cnt;
   int         last_xfer_cyc;
   int         done_cyc;
   logic       prev_hs;
   logic       hold_act;
   logic [2:0] held_w;
   logic [2:0] held_d;
   logic [7:0] exp_fcnt;

   kernel_scan_gen #(
      .WIDTH_LAST (7),
      .DEPTH_LAST (7)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .addr_ready    (addr_ready),
      .address_width (address_width),
      .address_depth (address_depth),
      .addr_valid    (addr_valid),
      .kernel_valid  (kernel_valid),
      .busy          (busy),
      .done          (done),
      .frame_cnt     (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard on transfers, handshake-to-kernel_valid delay, hold stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hs  = 1'b0;
         hold_act = 1'b0;
      end else begin
         check("kernel_valid_delay", 32'(kernel_valid), 32'(prev_hs));
         if (kernel_valid) kv_cnt++;
         if (hold_act) begin
            check("hold_valid", 32'(addr_valid), 32'd1);
            check("hold_addr", 32'({address_width, address_depth}), 32'({held_w, held_d}));
         end
         if (addr_valid && addr_ready) begin
            xfer_cnt++;
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("xfer_unexpected", 32'({address_width, address_depth}), 32'hFFFF_FFFF);
            end else begin
               addr_t e;
               e = exp_q.pop_front();
               check("xfer_width", 32'(address_width), 32'(e.w));
               check("xfer_depth", 32'(address_depth), 32'(e.d));
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         hold_act = addr_valid && !addr_ready;
         held_w   = address_width;
         held_d   = address_depth;
         prev_hs  = addr_valid && addr_ready;
      end
   end

   task automatic push_expected(input int n);
      for (int i = 0; i < n; i++) begin
         addr_t e;
         e.w = 3'(WFirst + i % NW);
         e.d = 3'(i / NW);
         exp_q.push_back(e);
      end
   endtask

   task automatic run_frame(input vec_t v);
      int n;
      bit fin;
      bit ab;
      n = (v.abort_idx >= 0) ? v.abort_idx + 1 : Tot;
      push_expected(n);
      xfer_cnt = 0;
      kv_cnt   = 0;
      done_cnt = 0;
      fin      = 1'b0;
      start    = 1'b1;
      step();
      start    = 1'b0;
      check("scan_entry_busy", 32'(busy), 32'd1);
      for (int c = 0; c < MaxCyc && !fin; c++) begin
         if (done) begin
            start = 1'(v.start_in_done);
            step();
            start = 1'b0;
            check("post_done_idle", 32'(busy), 32'd0);
            step();
            check("start_in_done_ignored", 32'(busy), 32'd0);
            fin = 1'b1;
         end else begin
            case (v.mode)
               0:       addr_ready = 1'b1;
               1:       addr_ready = (c % 2 == 0);
               default: addr_ready = 1'($urandom_range(0, 1));
            endcase
            if (v.mode == 2) start = 1'($urandom_range(0, 1));
            ab = (v.abort_idx >= 0 && xfer_cnt == v.abort_idx && addr_ready && addr_valid) ||
                 (v.abort_last != 0 && busy && !addr_valid);
            abort = ab;
            step();
            abort = 1'b0;
            start = 1'b0;
            if (ab) begin
               addr_ready = 1'b0;
               check("abort_busy", 32'(busy), 32'd0);
               check("abort_valid", 32'(addr_valid), 32'd0);
               check("abort_width", 32'(address_width), 32'd0);
               check("abort_depth", 32'(address_depth), 32'd0);
               repeat (3) step();
               fin = 1'b1;
            end
         end
      end
      addr_ready = 1'b0;
      start      = 1'b0;
      if (!fin) begin
         n_tests++;
         n_fail++;
         $display("FAIL frame_timeout: got no end after %0d cycles, required done or abort", MaxCyc);
      end
      exp_fcnt = exp_fcnt + 8'(v.exp_fdelta);
      check("frame_xfers", xfer_cnt, v.exp_xfers);
      check("frame_kernel_valid", kv_cnt, v.exp_kv);
      check("frame_done_pulses", done_cnt, v.exp_done);
      check("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
      check("scoreboard_empty", exp_q.size(), 0);
      if (v.exp_done != 0) check("done_latency", done_cyc - last_xfer_cyc, 2);
      exp_q.delete();
   endtask

   task automatic reset_mid_frame();
      push_expected(Idx54);
      xfer_cnt   = 0;
      kv_cnt     = 0;
      done_cnt   = 0;
      start      = 1'b1;
      step();
      start      = 1'b0;
      addr_ready = 1'b1;
      for (int c = 0; c < MaxCyc && xfer_cnt != Idx54; c++) step();
      addr_ready = 1'b0;
      check("rst_at_width", 32'(address_width), 32'd5);
      check("rst_at_depth", 32'(address_depth), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_width", 32'(address_width), 32'd0);
      check("rst_async_depth", 32'(address_depth), 32'd0);
      check("rst_async_valid", 32'(addr_valid), 32'd0);
      check("rst_async_kv", 32'(kernel_valid), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_fcnt", 32'(frame_cnt), 32'd0);
      check("rst_queue", exp_q.size(), 0);
      exp_q.delete();
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      check("rst_wait_busy", 32'(busy), 32'd0);
      check("rst_wait_valid", 32'(addr_valid), 32'd0);
      exp_fcnt = 8'd0;
      run_frame(vecs[0]);
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      addr_ready = 1'b0;
      exp_fcnt   = 8'd0;
      vecs[0] = '{0, -1, 0, 0, Tot, Tot, 1, 1};
      vecs[1] = '{1, -1, 0, 0, Tot, Tot, 1, 1};
      vecs[2] = '{2, -1, 0, 1, Tot, Tot, 1, 1};
      vecs[3] = '{0, Idx32, 0, 0, Idx32 + 1, Idx32 + 1, 0, 0};
      vecs[4] = '{1, Tot - 1, 0, 0, Tot, Tot, 0, 0};
      vecs[5] = '{0, -1, 1, 0, Tot, Tot, 0, 0};
      wrapv   = '{0, -1, 0, 1, Tot, Tot, 1, 1};

      #3;
      check("reset_width", 32'(address_width), 32'd0);
      check("reset_depth", 32'(address_depth), 32'd0);
      check("reset_valid", 32'(addr_valid), 32'd0);
      check("reset_kv", 32'(kernel_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_fcnt", 32'(frame_cnt), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      check("idle_no_start", 32'(busy), 32'd0);

      for (int i = 0; i < 6; i++) run_frame(vecs[i]);
      reset_mid_frame();
      for (int i = 0; i < 255; i++) run_frame(wrapv);
      check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
